// File: rtl/data_axi_bridge_pkg.sv
// Shared AXI3 definitions for the data-side bridge: state encodings,
// burst/size codes and the default transaction ID.
package axi_defs;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_ADDR = ST_RD_ADDR,
    RD_DATA = ST_RD_DATA,
    WR_REQ  = ST_WR_REQ,
    WR_RESP = ST_WR_RESP,
    DONE    = ST_DONE
  } bridge_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [3:0] AXI_DEFAULT_ID = 4'd1;

  // Memory-stage size codes map directly onto AXI AxSIZE (bytes = 2^size).
  function automatic logic [2:0] axi_size(input logic [1:0] req_size);
    return {1'b0, req_size};
  endfunction

endpackage

// File: rtl/data_axi_bridge.sv
// Data-side bridge: turns each memory-stage request into one single-beat
// AXI3 read or write and stalls the pipeline until it completes.
module data_axi_bridge
  import axi_defs::*;
#(
  parameter logic [3:0] AXI_ID = AXI_DEFAULT_ID
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        req_en,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        data_ok,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata_axi,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  bridge_state_t state, next_state;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] rdata_q;
  logic        aw_done;
  logic        w_done;

  // Response codes and IDs are not used: errors complete like OKAY.
  logic unused_inputs;
  assign unused_inputs = ^{rid, bid, rresp, bresp, rlast};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    data_ok    = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = req_en;
        if (req_en) begin
          next_state = req_write ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        stall   = 1'b1;
        arvalid = 1'b1;
        if (arready) begin
          next_state = RD_DATA;
        end
      end
      RD_DATA: begin
        stall  = 1'b1;
        rready = 1'b1;
        if (rvalid) begin
          next_state = DONE;
        end
      end
      WR_REQ: begin
        stall   = 1'b1;
        awvalid = !aw_done;
        wvalid  = !w_done;
        // Each channel may finish in this cycle or an earlier one.
        if ((aw_done || awready) && (w_done || wready)) begin
          next_state = WR_RESP;
        end
      end
      WR_RESP: begin
        stall  = 1'b1;
        bready = 1'b1;
        if (bvalid) begin
          next_state = DONE;
        end
      end
      DONE: begin
        data_ok    = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
    end else if (state == IDLE && req_en) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      sel_q   <= req_sel;
      wdata_q <= req_wdata;
      write_q <= req_write;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
    end else if (state == RD_DATA && rvalid) begin
      rdata_q <= rdata_axi;
    end
  end

  // Flags clear outside WR_REQ so every write starts with both channels open.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != WR_REQ) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  logic unused_write_q;
  assign unused_write_q = write_q;

  assign rdata   = rdata_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = axi_size(size_q);
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = axi_size(size_q);
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = sel_q;
  assign wlast   = wvalid;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed self-checking bench for data_axi_bridge; the bench plays the
// memory stage and a scripted AXI slave, cycle by cycle.
module tb_data_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_en, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [3:0]  req_sel;
  logic [31:0] rdata;
  logic        stall, data_ok;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int checks = 0;
  int failures = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  data_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .req_en(req_en), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_sel(req_sel), .req_wdata(req_wdata),
    .rdata(rdata), .stall(stall), .data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    if (stall) stall_cnt++;
  endtask

  initial begin
    resetn = 1'b0;
    req_en = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'd0; req_sel = 4'd0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = 4'd7; rdata_axi = '0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    bid = 4'd7; bresp = 2'd0; bvalid = 1'b0;
    stall_cnt = 0;

    // Reset state
    next_cycle(); req_en = 1'b1; settle();
    check("rst_stall_follows_en", stall, 1);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready, data_ok}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_araddr", araddr, 0);
    check("const_ids", {arid, awid, wid}, 12'h111);
    check("const_len_burst", {arlen, awlen, arburst, awburst}, 12'h005);
    check("const_lock_cache_prot", {arlock, awlock, arcache, awcache, arprot, awprot}, 0);
    req_en = 1'b0; #1;
    check("rst_stall_idle", stall, 0);
    next_cycle(); resetn = 1'b1; settle();

    // LW 0x8000_0010, zero-wait slave
    next_cycle(); stall_cnt = 0;
    req_en = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd2; settle();
    check("lw_c0_stall", stall, 1);
    check("lw_c0_arvalid", arvalid, 0);
    next_cycle(); req_en = 1'b0; arready = 1'b1; settle();
    check("lw_c1_arvalid", arvalid, 1);
    check("lw_c1_araddr", araddr, 32'h8000_0010);
    check("lw_c1_arsize_arlen", {arsize, arlen}, {3'd2, 4'd0});
    next_cycle(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'hDEAD_BEEF; settle();
    check("lw_c2_rready", rready, 1);
    check("lw_c2_arvalid", arvalid, 0);
    check("lw_c2_rdata_old", rdata, 0);
    next_cycle(); rvalid = 1'b0; rdata_axi = '0; settle();
    check("lw_c3_data_ok", data_ok, 1);
    check("lw_c3_stall", stall, 0);
    check("lw_rdata", rdata, 32'hDEAD_BEEF);
    check("lw_stall_cycles", stall_cnt, 3);
    next_cycle(); settle();
    check("lw_c4_data_ok", data_ok, 0);

    // SB 0x8000_0003
    next_cycle(); stall_cnt = 0;
    req_en = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0003; req_size = 2'd0;
    req_sel = 4'b1000; req_wdata = 32'h5A5A_5A5A; settle();
    check("sb_c0_stall", stall, 1);
    next_cycle(); req_en = 1'b0; awready = 1'b1; wready = 1'b1; settle();
    check("sb_c1_aw_w_valid", {awvalid, wvalid}, 2'b11);
    check("sb_c1_awaddr", awaddr, 32'h8000_0003);
    check("sb_c1_awsize", awsize, 0);
    check("sb_c1_wstrb_wlast", {wstrb, wlast}, {4'b1000, 1'b1});
    check("sb_c1_wdata", wdata, 32'h5A5A_5A5A);
    next_cycle(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b10; settle();
    check("sb_c2_bready", bready, 1);
    check("sb_c2_valids_low", {awvalid, wvalid, wlast}, 0);
    next_cycle(); bvalid = 1'b0; bresp = 2'b00; settle();
    check("sb_c3_data_ok", data_ok, 1);
    check("sb_rdata_kept", rdata, 32'hDEAD_BEEF);
    check("sb_stall_cycles", stall_cnt, 3);

    // SH with wready 3 cycles after awready
    next_cycle();
    req_en = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0006; req_size = 2'd1;
    req_sel = 4'b1100; req_wdata = 32'h1234_1234; settle();
    next_cycle(); req_en = 1'b0; awready = 1'b1; settle();
    check("sh_c1_valids", {awvalid, wvalid}, 2'b11);
    check("sh_c1_awsize", awsize, 1);
    next_cycle(); awready = 1'b0; settle();
    check("sh_c2_valids", {awvalid, wvalid, bready}, 3'b010);
    next_cycle(); settle();
    check("sh_c3_valids", {awvalid, wvalid, bready}, 3'b010);
    next_cycle(); wready = 1'b1; settle();
    check("sh_c4_valids", {awvalid, wvalid, wstrb, bready}, {2'b01, 4'b1100, 1'b0});
    next_cycle(); wready = 1'b0; bvalid = 1'b1; settle();
    check("sh_c5_resp", {awvalid, wvalid, bready}, 3'b001);
    next_cycle(); bvalid = 1'b0; settle();
    check("sh_c6_data_ok", data_ok, 1);

    // Read with arready in the 4th AR cycle, rvalid in the 2nd R cycle
    next_cycle(); stall_cnt = 0;
    req_en = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0020; req_size = 2'd2; settle();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); req_en = 1'b0; req_addr = 32'hFFFF_FFFF; settle();
      check("slow_ar_wait", {arvalid, araddr}, {1'b1, 32'h8000_0020});
    end
    next_cycle(); arready = 1'b1; settle();
    check("slow_ar_hs", {arvalid, araddr}, {1'b1, 32'h8000_0020});
    next_cycle(); arready = 1'b0; rdata_axi = 32'h1111_1111; settle();
    check("slow_r_wait", {rready, arvalid}, 2'b10);
    next_cycle(); rvalid = 1'b1; rdata_axi = 32'hCAFE_F00D; settle();
    check("slow_r_before_capture", rdata, 32'hDEAD_BEEF);
    next_cycle(); rvalid = 1'b0; rdata_axi = '0; settle();
    check("slow_data_ok", data_ok, 1);
    check("slow_rdata", rdata, 32'hCAFE_F00D);
    check("slow_stall_cycles", stall_cnt, 7);

    // Back-to-back loads with req_en held through DONE
    next_cycle();
    req_en = 1'b1; req_addr = 32'h8000_0040; settle();
    next_cycle(); arready = 1'b1; settle();
    next_cycle(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0102_0304; settle();
    next_cycle(); rvalid = 1'b0; settle();
    check("b2b_done", {data_ok, stall, arvalid}, 3'b100);
    next_cycle(); req_addr = 32'h8000_0044; settle();
    check("b2b_idle", {data_ok, stall, arvalid}, 3'b010);
    next_cycle(); req_en = 1'b0; arready = 1'b1; settle();
    check("b2b_second_ar", {arvalid, araddr}, {1'b1, 32'h8000_0044});
    next_cycle(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0506_0708; settle();
    next_cycle(); rvalid = 1'b0; settle();
    check("b2b_second_rdata", {data_ok, rdata}, {1'b1, 32'h0506_0708});

    // Reset asserted while in RD_DATA
    next_cycle();
    req_en = 1'b1; req_addr = 32'h8000_0050; settle();
    next_cycle(); req_en = 1'b0; arready = 1'b1; settle();
    next_cycle(); arready = 1'b0; settle();
    check("mid_rst_in_rd_data", rready, 1);
    resetn = 1'b0; #1;
    check("mid_rst_outputs", {arvalid, rready, awvalid, wvalid, bready, data_ok, stall}, 0);
    check("mid_rst_rdata", rdata, 0);
    next_cycle(); settle();
    check("mid_rst_next_cycle", {arvalid, rready, awvalid, wvalid, bready, data_ok}, 0);
    check("mid_rst_araddr", araddr, 0);
    resetn = 1'b1;
    next_cycle();
    req_en = 1'b1; req_addr = 32'h8000_0060; settle();
    check("post_rst_accept", {stall, arvalid}, 2'b10);
    next_cycle(); req_en = 1'b0; arready = 1'b1; settle();
    check("post_rst_ar", {arvalid, araddr}, {1'b1, 32'h8000_0060});
    next_cycle(); arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0BAD_F00D; settle();
    next_cycle(); rvalid = 1'b0; settle();
    check("post_rst_done", {data_ok, rdata}, {1'b1, 32'h0BAD_F00D});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_axi_bridge.md
# data_axi_bridge

Data-side bridge between the CPU memory stage and the SoC AXI3 interconnect. It is the responder to the memory stage's request bus (`en`, `write`, `addr`, `writedata`, `sel`, `size`) and returns read data on `mem_read`. It converts each request into one single-beat AXI read or write transaction and stalls the pipeline until that transaction completes. One transaction is outstanding at a time.

## Interface
- `AXI_ID`, default 4'd1: constant ID on `arid`/`awid`/`wid`.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_en` in 1: request valid (memory stage `en`, already exception-gated).
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word.
- `req_sel` in 4: byte strobes for stores.
- `req_wdata` in 32: lane-replicated store data.
- `rdata` out 32: last completed read word, lane-aligned and not shifted.
- `stall` out 1: freeze request to pipeline.
- `data_ok` out 1: one-cycle completion pulse.
- `araddr`/`arsize`/`arvalid` out 32/3/1; `arready` in 1.
- `rdata_axi`/`rresp`/`rlast`/`rvalid` in 32/2/1/1; `rready` out 1.
- `awaddr`/`awsize`/`awvalid` out 32/3/1; `awready` in 1.
- `wdata`/`wstrb`/`wlast`/`wvalid` out 32/4/1/1; `wready` in 1.
- `bresp`/`bvalid` in 2/1; `bready` out 1.
- `arid`/`awid`/`wid` out 4: `AXI_ID`. `arlen`/`awlen` out 4: 0. `arburst`/`awburst` out 2: 01. `arlock`/`awlock`, `arcache`/`awcache`, `arprot`/`awprot`: 0. `rid`/`bid` in: ignored.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE with `req_en`=1:
  - Latch addr, size, sel, wdata and write into internal registers.
  - Go to WR_REQ if write, otherwise RD_ADDR.
  - `stall`=1 combinationally in this same cycle.
- RD_ADDR: `arvalid`=1. On `arready`, go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, latch `rdata_axi` into `rdata` and go to DONE.
- WR_REQ:
  - `awvalid` and `wvalid` both assert on entry.
  - Each drops after its own handshake, tracked by flags `aw_done` and `w_done`.
  - When both handshakes are done (same cycle or different cycles), go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, go to DONE.
- DONE: `data_ok`=1 and `stall`=0. The pipeline advances at this edge. `req_en` is ignored in DONE. Next state is IDLE unconditionally.
- `stall` = (state ∉ {IDLE, DONE}) | (state==IDLE & `req_en`).
- `arsize`/`awsize` = {1'b0, latched size}. `wstrb` = latched sel. `wdata` = latched wdata. `wlast`=1 whenever `wvalid`=1.
- `rresp`/`bresp` errors are ignored; the transaction completes normally.
- `rdata` holds its value until the next read completes. Writes do not change it.
- AXI valid signals are never withdrawn before their handshake.
- Reset values: state IDLE; all valid/ready outputs 0; `rdata` 0; `data_ok` 0; address/data registers 0. `stall` = `req_en`.
- Reset asserted mid-transaction: return to IDLE immediately and abandon the AXI transaction. The whole SoC is reset together, so no recovery is needed.

## Timing
- Minimum read, zero-wait slave:
  - cycle 0: IDLE, `req_en`=1.
  - cycle 1: `arvalid`; `arready`=1.
  - cycle 2: `rready`; `rvalid`=1.
  - cycle 3: DONE, `data_ok`=1, `stall`=0.
  - `stall` is high for cycles 0-2.
- Minimum write: cycle 1 AW+W handshake, cycle 2 B handshake, cycle 3 DONE. `stall` is high for 3 cycles.
- Back-to-back requests: the next request is accepted no earlier than the cycle after DONE, giving 1 idle cycle between transactions.
- Each AXI handshake completes on a rising edge with valid & ready both high.

## Structure
- Shared package (`axi_defs`) holds:
  - State encoding localparams.
  - `AXI_BURST_INCR` = 2'b01.
  - Size codes.
  - The default ID.
- No sub-module; the write-channel completion flags are inline.

## Test plan
- LW at 0x8000_0010, slave returns 0xDEADBEEF with arready/rvalid at zero wait -> `stall` high 3 cycles; `data_ok` in cycle 3; `rdata`=0xDEADBEEF; `arsize`=2, `arlen`=0.
- SB at 0x8000_0003, wdata 0x5A5A5A5A, sel 4'b1000 -> `awsize`=0, `wstrb`=4'b1000, `wlast`=1; one B handshake, then `data_ok`.
- SH write with wready 3 cycles after awready -> `awvalid` drops after its handshake; `wvalid` held until wready; WR_RESP entered only after both handshakes.
- Read with arready delayed 4 cycles and rvalid delayed 2 -> `araddr`/`arvalid` stable throughout; `stall` high 7 cycles; `rdata` captured only on rvalid.
- Two consecutive loads, second `req_en` held through DONE -> second AR issued exactly 2 cycles after the first `data_ok`, not in the DONE cycle.
- `resetn` pulled low in RD_DATA -> next cycle all valid/ready outputs 0, `rdata`=0, state IDLE; a subsequent LW completes normally.
